// File: rtl/parity_frame_rx.sv
// parity_frame_rx: deframes start/data/parity/stop serial units, checks parity and stop, counts errors
module parity_frame_rx #(
  parameter int DATA_W = 8,
  parameter bit PARITY_ODD = 1'b0,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              clr_cnt,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  err_cnt
);
  localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t            state;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] sh;
  logic              rx;
  logic              p_r;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      sh         <= '0;
      rx         <= 1'b0;
      p_r        <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      err_cnt    <= '0;
    end else begin
      dout_valid <= 1'b0;
      if (bit_valid) begin
        case (state)
          IDLE: if (!bit_in) begin
            state <= DATA;
            busy  <= 1'b1;
            idx   <= '0;
            rx    <= 1'b0;
          end
          DATA: begin
            sh[idx] <= bit_in;
            rx      <= rx ^ bit_in;
            idx     <= idx + IW'(1);
            if (idx == IW'(DATA_W - 1)) state <= PARITY;
          end
          PARITY: begin
            p_r   <= rx ^ bit_in ^ PARITY_ODD;
            state <= STOP;
          end
          default: begin
            dout       <= sh;
            dout_valid <= 1'b1;
            parity_err <= p_r;
            frame_err  <= ~bit_in;
            busy       <= 1'b0;
            state      <= IDLE;
            if ((p_r | ~bit_in) && !(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
          end
        endcase
      end
      if (clr_cnt) err_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx: table-driven and directed checks of parity_frame_rx
module tb_parity_frame_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_valid = 1'b0;
  logic bit_in = 1'b1;
  logic clr_cnt_a = 1'b0;
  logic clr_cnt_b = 1'b0;
  logic [7:0] dout_a, dout_b;
  logic dout_valid_a, dout_valid_b, parity_err_a, parity_err_b, frame_err_a, frame_err_b, busy_a, busy_b;
  logic [7:0] err_cnt_a;
  logic [1:0] err_cnt_b;
  int n_chk = 0;
  int n_fail = 0;
  logic bexp = 1'b0;
  always #5 clk = ~clk;
  parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1'b0), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .clr_cnt(clr_cnt_a),
    .dout(dout_a), .dout_valid(dout_valid_a), .parity_err(parity_err_a), .frame_err(frame_err_a),
    .busy(busy_a), .err_cnt(err_cnt_a));
  parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .clr_cnt(clr_cnt_b),
    .dout(dout_b), .dout_valid(dout_valid_b), .parity_err(parity_err_b), .frame_err(frame_err_b),
    .busy(busy_b), .err_cnt(err_cnt_b));
  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    logic       pe;
    logic       fe;
    logic [7:0] cnt;
  } vec_t;
  vec_t tbl[5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic strobe(input logic b, input int gap, input logic nb, input logic c);
    for (int k = 0; k < gap; k++) begin
      @(negedge clk);
      if (c) begin
        chk("busy_hold", {31'd0, busy_a}, {31'd0, bexp});
        chk("no_valid_gap", {31'd0, dout_valid_a}, 32'd0);
      end
    end
    bit_valid = 1'b1;
    bit_in = b;
    @(negedge clk);
    bit_valid = 1'b0;
    bit_in = 1'b1;
    bexp = nb;
    if (c) chk("busy", {31'd0, busy_a}, {31'd0, nb});
  endtask
  task automatic frame(input logic [7:0] d, input logic p, input logic s, input int maxgap,
                       input logic c, input logic clr);
    strobe(1'b0, $urandom_range(0, maxgap), 1'b1, c);
    for (int i = 0; i < 8; i++) begin
      strobe(d[i], $urandom_range(0, maxgap), 1'b1, c);
      if (c) chk("no_valid_mid", {31'd0, dout_valid_a}, 32'd0);
    end
    strobe(p, $urandom_range(0, maxgap), 1'b1, c);
    if (c) chk("no_valid_mid", {31'd0, dout_valid_a}, 32'd0);
    clr_cnt_b = clr;
    strobe(s, $urandom_range(0, maxgap), 1'b0, c);
    clr_cnt_b = 1'b0;
  endtask
  task automatic check_done(input logic [7:0] d, input logic pe, input logic fe, input logic [7:0] cnt);
    chk("dout", {24'd0, dout_a}, {24'd0, d});
    chk("dout_valid", {31'd0, dout_valid_a}, 32'd1);
    chk("parity_err", {31'd0, parity_err_a}, {31'd0, pe});
    chk("frame_err", {31'd0, frame_err_a}, {31'd0, fe});
    chk("err_cnt", {24'd0, err_cnt_a}, {24'd0, cnt});
    @(negedge clk);
    chk("valid_pulse_end", {31'd0, dout_valid_a}, 32'd0);
    chk("dout_hold", {24'd0, dout_a}, {24'd0, d});
  endtask
  initial begin
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[2] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
    tbl[4] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 8'd3};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_dout", {24'd0, dout_a}, 32'd0);
    chk("rst_flags", {28'd0, dout_valid_a, parity_err_a, frame_err_a, busy_a}, 32'd0);
    chk("rst_cnt", {24'd0, err_cnt_a}, 32'd0);
    chk("rst_cnt_b", {30'd0, err_cnt_b}, 32'd0);
    for (int v = 0; v < 5; v++) begin
      frame(tbl[v].d, tbl[v].p, tbl[v].s, 0, 1'b0, 1'b0);
      check_done(tbl[v].d, tbl[v].pe, tbl[v].fe, tbl[v].cnt);
    end
    for (int i = 0; i < 4; i++) begin
      strobe(1'b1, $urandom_range(0, 5), 1'b0, 1'b1);
      chk("idle_no_valid", {31'd0, dout_valid_a}, 32'd0);
    end
    frame(8'h5A, 1'b0, 1'b1, 5, 1'b1, 1'b0);
    check_done(8'h5A, 1'b0, 1'b0, 8'd3);
    strobe(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) strobe(1'b1, 1, 1'b1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bexp = 1'b0;
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_dout", {24'd0, dout_a}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_valid", {31'd0, dout_valid_a}, 32'd0);
    end
    frame(8'h0F, 1'b0, 1'b1, 2, 1'b1, 1'b0);
    check_done(8'h0F, 1'b0, 1'b0, 8'd0);
    for (int i = 1; i <= 5; i++) begin
      frame(8'h01, 1'b0, 1'b1, 1, 1'b0, 1'b0);
      chk("sat_pe_b", {31'd0, parity_err_b}, 32'd1);
      chk("sat_cnt_b", {30'd0, err_cnt_b}, (i > 3) ? 32'd3 : i);
      check_done(8'h01, 1'b1, 1'b0, 8'(i));
    end
    frame(8'h01, 1'b0, 1'b1, 1, 1'b0, 1'b1);
    chk("clr_wins_b", {30'd0, err_cnt_b}, 32'd0);
    check_done(8'h01, 1'b1, 1'b0, 8'd6);
    clr_cnt_a = 1'b1;
    @(negedge clk);
    clr_cnt_a = 1'b0;
    chk("clr_a", {24'd0, err_cnt_a}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
